// File: rtl/pulse_monitor.sv
// pulse_monitor: measures high time and period of a synchronous pulse stream, flags errors/timeouts, tracks lock
module pulse_monitor #(
    parameter int EXP_DURATION = 4,
    parameter int EXP_PERIOD   = 10,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT_CYC  = 4 * EXP_PERIOD,
    parameter int LOCK_COUNT   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_duration,
    output logic [CNT_W-1:0] meas_period,
    output logic             duration_err,
    output logic             period_err,
    output logic             err_sticky,
    output logic             timeout,
    output logic             locked
);
    localparam logic [CNT_W-1:0] EXP_D  = CNT_W'(EXP_DURATION);
    localparam logic [CNT_W-1:0] EXP_P  = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    if (EXP_DURATION >= EXP_PERIOD || EXP_DURATION == 0 ||
        longint'(TIMEOUT_CYC) >= (64'd1 << CNT_W)) begin : g_param_check
        $error("pulse_monitor: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state, state_nxt;

    logic             pulse_d, rise, meas, tmo, dur_bad, per_bad;
    logic [CNT_W-1:0] hi_cnt, per_cnt, dur_lat, good_cnt, good_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = (!enable || tmo) ? IDLE :
                    (state == IDLE)  ? (rise ? HIGH : IDLE) :
                    (state == HIGH)  ? (pulse_in ? HIGH : LOW) :
                                       (rise ? HIGH : LOW);
    end

    // a closing rise outranks a timeout landing on the same cycle
    always_comb begin
        rise     = pulse_in & ~pulse_d;
        meas     = (state == LOW) & rise;
        tmo      = (state != IDLE) & ~rise & (per_cnt == TMO);
        dur_bad  = dur_lat != EXP_D;
        per_bad  = per_cnt != EXP_P;
        good_nxt = (dur_bad | per_bad) ? '0 :
                   (good_cnt >= LOCK_C) ? LOCK_C : good_cnt + ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_d       <= 1'b1;
            hi_cnt        <= '0;
            per_cnt       <= '0;
            dur_lat       <= '0;
            good_cnt      <= '0;
            meas_valid    <= 1'b0;
            meas_duration <= '0;
            meas_period   <= '0;
            duration_err  <= 1'b0;
            period_err    <= 1'b0;
            err_sticky    <= 1'b0;
            timeout       <= 1'b0;
            locked        <= 1'b0;
        end else begin
            pulse_d    <= pulse_in;
            meas_valid <= enable & meas;
            timeout    <= enable & tmo;
            if (!enable || tmo) begin
                hi_cnt   <= '0;
                per_cnt  <= '0;
                dur_lat  <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
                if (enable) err_sticky <= 1'b1;
            end else if (rise && state != HIGH) begin
                hi_cnt  <= ONE;
                per_cnt <= ONE;
                if (meas) begin
                    meas_duration <= dur_lat;
                    meas_period   <= per_cnt;
                    duration_err  <= dur_bad;
                    period_err    <= per_bad;
                    err_sticky    <= err_sticky | dur_bad | per_bad;
                    good_cnt      <= good_nxt;
                    locked        <= good_nxt == LOCK_C;
                end
            end else if (state != IDLE) begin
                per_cnt <= per_cnt + ONE;
                if (state == HIGH && pulse_in)  hi_cnt  <= hi_cnt + ONE;
                if (state == HIGH && !pulse_in) dur_lat <= hi_cnt;
            end
        end
    end
endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: directed scenarios plus random streams checked against a timestamp-based model
module tb_pulse_monitor;
    localparam int EXP_D = 4, EXP_P = 10, TMO = 40, LOCK = 3;

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b1, pulse_in = 1'b0;
    logic        meas_valid, duration_err, period_err, err_sticky, timeout, locked;
    logic [15:0] meas_duration, meas_period;

    int n_cmp = 0, n_err = 0, strobes = 0, tmos = 0;

    pulse_monitor dut (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .meas_valid(meas_valid), .meas_duration(meas_duration), .meas_period(meas_period),
        .duration_err(duration_err), .period_err(period_err), .err_sticky(err_sticky),
        .timeout(timeout), .locked(locked)
    );

    always #5 clk = ~clk;

    // model: an open period is a rise timestamp; duration and period are timestamp differences
    int          n = 0, t_rise = 0, t_fall = 0, m_good = 0;
    bit          m_prev = 1, m_armed = 0, m_fell = 0;
    logic        m_mv = 0, m_derr = 0, m_perr = 0, m_sticky = 0, m_tmo = 0, m_lock = 0;
    logic [15:0] m_dur = 0, m_per = 0;

    function automatic void model(input bit r, input bit e, input bit p);
        bit rs, bad;
        n++;
        m_mv  = 0;
        m_tmo = 0;
        if (r) begin
            m_prev = 1; m_armed = 0; m_good = 0;
            m_derr = 0; m_perr = 0; m_sticky = 0; m_lock = 0; m_dur = 0; m_per = 0;
            return;
        end
        rs = p & ~m_prev;
        m_prev = p;
        if (!e) begin
            m_armed = 0; m_good = 0; m_lock = 0;
        end else if (m_armed && rs) begin
            m_mv   = 1;
            m_dur  = 16'(t_fall - t_rise);
            m_per  = 16'(n - t_rise);
            m_derr = (m_dur != EXP_D);
            m_perr = (m_per != EXP_P);
            bad    = m_derr | m_perr;
            m_sticky = m_sticky | bad;
            m_good = bad ? 0 : (m_good < LOCK ? m_good + 1 : LOCK);
            m_lock = (m_good == LOCK);
            t_rise = n; m_fell = 0;
        end else if (m_armed && n - t_rise == TMO) begin
            m_tmo = 1; m_armed = 0; m_good = 0; m_lock = 0; m_sticky = 1;
        end else if (!m_armed && rs) begin
            m_armed = 1; t_rise = n; m_fell = 0;
        end else if (m_armed && !p && !m_fell) begin
            m_fell = 1; t_fall = n;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit p);
        reset = r; enable = e; pulse_in = p;
        @(posedge clk);
        model(r, e, p);
        #1;
        check("cycle", {meas_valid, meas_duration, meas_period, duration_err, period_err, err_sticky, timeout, locked},
                       {m_mv, m_dur, m_per, m_derr, m_perr, m_sticky, m_tmo, m_lock});
        strobes += int'(meas_valid);
        tmos    += int'(timeout);
    endtask

    task automatic pulses(input int hi, input int lo, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            for (int i = 0; i < hi; i++) tick(0, 1, 1);
            for (int i = 0; i < lo; i++) tick(0, 1, 0);
        end
    endtask

    task automatic rnd_pulses(input int hi, input int lo);
        for (int i = 0; i < hi + lo; i++)
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 99) != 0, i < hi);
    endtask

    initial begin
        tick(1, 1, 0);
        tick(1, 1, 0);
        check("reset_state", {meas_valid, meas_duration, meas_period, duration_err, period_err, err_sticky, timeout, locked}, '0);
        tick(0, 1, 0);
        // T1: nominal stream
        strobes = 0;
        pulses(4, 6, 6);
        check("t1_strobes", 64'(strobes), 5);
        check("t1_locked", locked, 1);
        check("t1_sticky", err_sticky, 0);
        // T2: wrong stream
        pulses(5, 10, 3);
        check("t2_values", {meas_duration, meas_period, duration_err, period_err}, {16'd5, 16'd15, 2'b11});
        check("t2_sticky_lock", {err_sticky, locked}, 2'b10);
        // T3: line high across reset release
        tick(1, 1, 1);
        tick(1, 1, 1);
        strobes = 0;
        for (int i = 0; i < 7; i++) tick(0, 1, 1);
        for (int i = 0; i < 3; i++) tick(0, 1, 0);
        pulses(4, 6, 2);
        check("t3_strobes", 64'(strobes), 1);
        check("t3_values", {meas_duration, meas_period, err_sticky}, {16'd4, 16'd10, 1'b0});
        // T4: lock then loss of pulses
        pulses(4, 6, 3);
        check("t4_locked", locked, 1);
        tmos = 0;
        for (int i = 0; i < 45; i++) tick(0, 1, 0);
        check("t4_timeouts", 64'(tmos), 1);
        check("t4_after", {locked, err_sticky}, 2'b01);
        strobes = 0;
        pulses(4, 6, 3);
        check("t4_resume", 64'(strobes), 2);
        // T5: reset mid-HIGH
        tick(0, 1, 1);
        tick(0, 1, 1);
        tick(1, 1, 1);
        check("t5_cleared", {meas_valid, meas_duration, meas_period, duration_err, period_err, err_sticky, timeout, locked}, '0);
        strobes = 0;
        tick(0, 1, 1);
        tick(0, 1, 1);
        for (int i = 0; i < 6; i++) tick(0, 1, 0);
        pulses(4, 6, 3);
        check("t5_strobes", 64'(strobes), 2);
        // T6: enable dropped mid-LOW after lock
        pulses(4, 6, 2);
        check("t6_locked", locked, 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 1);
        for (int i = 0; i < 2; i++) tick(0, 1, 0);
        strobes = 0; tmos = 0;
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        check("t6_quiet", {64'(strobes), 64'(tmos)} == 0, 1);
        check("t6_unlocked", {locked, err_sticky}, 2'b00);
        tick(0, 1, 0);
        tick(0, 1, 0);
        pulses(4, 6, 3);
        check("t6_strobes", 64'(strobes), 2);
        // random streams, mostly nominal with occasional errors, gaps, disables and resets
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 2) == 0) rnd_pulses(EXP_D, EXP_P - EXP_D);
            else rnd_pulses($urandom_range(1, 6),
                            $urandom_range(0, 9) == 0 ? $urandom_range(35, 50) : $urandom_range(1, 10));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
